// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width and memory arbiter enums.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_DATA  = 2'd1,
    OWN_FETCH = 2'd2,
    OWN_DBG   = 2'd3
  } arb_owner_e;

  typedef enum logic {
    ARB_IDLE      = 1'b0,
    ARB_WAIT_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_prio_sel.sv
// Fixed-priority requester picker (data > fetch > debug, with a fetch boost)
// and the memory-side mux for the winning requester.
module arb_prio_sel
  import riscv_pkg::*;
(
  input  logic            i_en,
  input  logic            i_boost,
  input  logic            i_d_req,
  input  logic            i_d_we,
  input  logic [3:0]      i_d_be,
  input  logic [XLEN-1:0] i_d_addr,
  input  logic [XLEN-1:0] i_d_wdata,
  input  logic            i_f_req,
  input  logic [XLEN-1:0] i_f_addr,
  input  logic            i_dbg_req,
  input  logic [XLEN-1:0] i_dbg_addr,
  output arb_owner_e      o_winner,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [3:0]      o_mem_be,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata
);

  // Pick the winner: boost lets a starved fetch jump ahead of data; debug always last.
  always_comb begin
    o_winner = OWN_NONE;
    if (!i_en) begin
      o_winner = OWN_NONE;
    end else if (i_boost && i_f_req) begin
      o_winner = OWN_FETCH;
    end else if (i_d_req) begin
      o_winner = OWN_DATA;
    end else if (i_f_req) begin
      o_winner = OWN_FETCH;
    end else if (i_dbg_req) begin
      o_winner = OWN_DBG;
    end else begin
      o_winner = OWN_NONE;
    end
  end

  // Route the winner onto the memory bus; fetch and debug are full-word reads.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = 4'h0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (o_winner)
      OWN_DATA: begin
        o_mem_req   = 1'b1;
        o_mem_we    = i_d_we;
        o_mem_be    = i_d_be;
        o_mem_addr  = i_d_addr;
        o_mem_wdata = i_d_wdata;
      end
      OWN_FETCH: begin
        o_mem_req  = 1'b1;
        o_mem_be   = 4'hF;
        o_mem_addr = i_f_addr;
      end
      OWN_DBG: begin
        o_mem_req  = 1'b1;
        o_mem_be   = 4'hF;
        o_mem_addr = i_dbg_addr;
      end
      default: begin
        o_mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter_chk.sv
// Protocol checker: the memory must not return read data when nothing is outstanding.
module mem_arbiter_chk (
  input logic i_clk,
  input logic i_rst,
  input logic i_idle,
  input logic i_mem_rvalid
);

  // Flag a stray read response seen while the arbiter is idle (it is dropped by the arbiter).
  always @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(i_idle && i_mem_rvalid))
        else $warning("mem_arbiter: mem_rvalid_i while idle, response dropped");
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way arbiter (data, fetch, debug) for a single-port unified memory with
// at most one outstanding read, response routing and fetch anti-starvation.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int MaxStarve = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [3:0]      d_be_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  input  logic            f_req_i,
  input  logic [XLEN-1:0] f_addr_i,
  output logic            f_gnt_o,
  output logic            f_rvalid_o,
  input  logic            dbg_req_i,
  input  logic [XLEN-1:0] dbg_addr_i,
  output logic            dbg_gnt_o,
  output logic            dbg_rvalid_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            stall_f_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam logic [2:0] StarveMax = 3'(MaxStarve);

  arb_state_e r_state;
  arb_owner_e r_owner;
  logic [2:0] r_starve_cnt;

  arb_owner_e w_winner;
  logic       w_en;
  logic       w_boost;
  logic       w_rsp;
  logic       w_accept_rd;

  // Outputs are forced quiet while reset is held, so arbitration only runs when idle and out of reset.
  assign w_en    = ~rst_i & (r_state == ARB_IDLE);
  assign w_boost = (r_starve_cnt == StarveMax);

  arb_prio_sel u_sel (
    .i_en        (w_en),
    .i_boost     (w_boost),
    .i_d_req     (d_req_i),
    .i_d_we      (d_we_i),
    .i_d_be      (d_be_i),
    .i_d_addr    (d_addr_i),
    .i_d_wdata   (d_wdata_i),
    .i_f_req     (f_req_i),
    .i_f_addr    (f_addr_i),
    .i_dbg_req   (dbg_req_i),
    .i_dbg_addr  (dbg_addr_i),
    .o_winner    (w_winner),
    .o_mem_req   (mem_req_o),
    .o_mem_we    (mem_we_o),
    .o_mem_be    (mem_be_o),
    .o_mem_addr  (mem_addr_o),
    .o_mem_wdata (mem_wdata_o)
  );

  assign d_gnt_o   = (w_winner == OWN_DATA)  & mem_gnt_i;
  assign f_gnt_o   = (w_winner == OWN_FETCH) & mem_gnt_i;
  assign dbg_gnt_o = (w_winner == OWN_DBG)   & mem_gnt_i;

  // A response is only meaningful while a read is outstanding; stray ones are dropped.
  assign w_rsp        = ~rst_i & (r_state == ARB_WAIT_RESP) & mem_rvalid_i;
  assign d_rvalid_o   = w_rsp & (r_owner == OWN_DATA);
  assign f_rvalid_o   = w_rsp & (r_owner == OWN_FETCH);
  assign dbg_rvalid_o = w_rsp & (r_owner == OWN_DBG);
  assign rdata_o      = w_rsp ? mem_rdata_i : '0;

  assign stall_f_o   = ~rst_i & f_req_i & ~f_gnt_o;
  assign w_accept_rd = mem_req_o & mem_gnt_i & ~mem_we_o;

  // Read-tracking FSM: remember who owns the single outstanding read until its data returns.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_NONE;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_accept_rd) begin
            r_state <= ARB_WAIT_RESP;
            r_owner <= w_winner;
          end else begin
            r_state <= ARB_IDLE;
            r_owner <= OWN_NONE;
          end
        end
        ARB_WAIT_RESP: begin
          if (mem_rvalid_i) begin
            r_state <= ARB_IDLE;
            r_owner <= OWN_NONE;
          end else begin
            r_state <= ARB_WAIT_RESP;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  // Count consecutive denied fetch cycles (including while blocked behind a read), saturating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve_cnt <= 3'd0;
    end else if (!f_req_i || f_gnt_o) begin
      r_starve_cnt <= 3'd0;
    end else if (r_starve_cnt != StarveMax) begin
      r_starve_cnt <= r_starve_cnt + 3'd1;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  mem_arbiter_chk u_chk (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_idle       (r_state == ARB_IDLE),
    .i_mem_rvalid (mem_rvalid_i)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter, checked against a
// transaction-level reference model of the arbitration rules.
module tb_mem_arbiter;
  import riscv_pkg::*;

  localparam int MAXS = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o;
  logic        f_req_i;
  logic [31:0] f_addr_i;
  logic        f_gnt_o, f_rvalid_o;
  logic        dbg_req_i;
  logic [31:0] dbg_addr_i;
  logic        dbg_gnt_o, dbg_rvalid_o;
  logic [31:0] rdata_o;
  logic        stall_f_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.MaxStarve(MAXS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o), .f_rvalid_o(f_rvalid_o),
    .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o), .rdata_o(rdata_o), .stall_f_o(stall_f_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who has a read in flight (0 none, 1 data, 2 fetch, 3 debug)
  // and how many consecutive cycles fetch has been refused.
  int m_pend   = 0;
  int m_starve = 0;
  int m_win    = 0;
  bit e_dg, e_fg, e_bg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample at the falling edge and compare every output with the model.
  task automatic eval_check();
    bit rv;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    bit e_we;
    @(negedge clk_i);
    m_win = 0;
    if (!rst_i && m_pend == 0) begin
      if (f_req_i && m_starve >= MAXS) m_win = 2;
      else if (d_req_i)                m_win = 1;
      else if (f_req_i)                m_win = 2;
      else if (dbg_req_i)              m_win = 3;
    end
    e_we    = (m_win == 1) ? d_we_i : 1'b0;
    e_be    = (m_win == 1) ? d_be_i : ((m_win != 0) ? 4'hF : 4'h0);
    e_addr  = (m_win == 1) ? d_addr_i : (m_win == 2) ? f_addr_i : (m_win == 3) ? dbg_addr_i : 32'h0;
    e_wdata = (m_win == 1) ? d_wdata_i : 32'h0;
    e_dg = (m_win == 1) && mem_gnt_i;
    e_fg = (m_win == 2) && mem_gnt_i;
    e_bg = (m_win == 3) && mem_gnt_i;
    rv = !rst_i && (m_pend != 0) && mem_rvalid_i;
    chk("mem_req", {31'h0, mem_req_o}, {31'h0, m_win != 0});
    chk("mem_we", {31'h0, mem_we_o}, {31'h0, e_we});
    chk("mem_be", {28'h0, mem_be_o}, {28'h0, e_be});
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_wdata", mem_wdata_o, e_wdata);
    chk("d_gnt", {31'h0, d_gnt_o}, {31'h0, e_dg});
    chk("f_gnt", {31'h0, f_gnt_o}, {31'h0, e_fg});
    chk("dbg_gnt", {31'h0, dbg_gnt_o}, {31'h0, e_bg});
    chk("d_rvalid", {31'h0, d_rvalid_o}, {31'h0, rv && m_pend == 1});
    chk("f_rvalid", {31'h0, f_rvalid_o}, {31'h0, rv && m_pend == 2});
    chk("dbg_rvalid", {31'h0, dbg_rvalid_o}, {31'h0, rv && m_pend == 3});
    chk("rdata", rdata_o, rv ? mem_rdata_i : 32'h0);
    chk("stall_f", {31'h0, stall_f_o}, {31'h0, !rst_i && f_req_i && !e_fg});
  endtask

  // Advance one clock and update the model from the inputs seen during the cycle.
  task automatic advance();
    @(posedge clk_i);
    if (rst_i) begin
      m_pend   = 0;
      m_starve = 0;
    end else begin
      if (m_pend == 0) begin
        if (m_win != 0 && mem_gnt_i && !(m_win == 1 && d_we_i)) m_pend = m_win;
      end else if (mem_rvalid_i) begin
        m_pend = 0;
      end
      if (!f_req_i || e_fg) m_starve = 0;
      else if (m_starve < MAXS) m_starve = m_starve + 1;
    end
    #1;
  endtask

  task automatic step();
    eval_check();
    advance();
  endtask

  initial begin
    rst_i = 1'b1; d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0; d_addr_i = 32'h0;
    d_wdata_i = 32'h0; f_req_i = 1'b0; f_addr_i = 32'h0; dbg_req_i = 1'b0;
    dbg_addr_i = 32'h0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #1;
    step();
    // Requests while reset is held must see all outputs quiet.
    f_req_i = 1'b1; mem_gnt_i = 1'b1;
    step();
    rst_i = 1'b0; f_req_i = 1'b0; mem_gnt_i = 1'b0;
    step();

    // Fetch-only read.
    f_req_i = 1'b1; f_addr_i = 32'h100; mem_gnt_i = 1'b1;
    eval_check();
    chk("t1_f_gnt", {31'h0, f_gnt_o}, 32'h1);
    chk("t1_stall", {31'h0, stall_f_o}, 32'h0);
    advance();
    f_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    eval_check();
    chk("t1_f_rvalid", {31'h0, f_rvalid_o}, 32'h1);
    chk("t1_rdata", rdata_o, 32'h0000_0013);
    advance();
    mem_rvalid_i = 1'b0;

    // Data write beats fetch, fetch follows next cycle.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h200; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'hF;
    f_req_i = 1'b1; f_addr_i = 32'h104; mem_gnt_i = 1'b1;
    eval_check();
    chk("t2_d_gnt", {31'h0, d_gnt_o}, 32'h1);
    chk("t2_mem_we", {31'h0, mem_we_o}, 32'h1);
    chk("t2_f_gnt", {31'h0, f_gnt_o}, 32'h0);
    chk("t2_stall", {31'h0, stall_f_o}, 32'h1);
    advance();
    d_req_i = 1'b0;
    eval_check();
    chk("t2_f_gnt_next", {31'h0, f_gnt_o}, 32'h1);
    advance();
    f_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    step();
    mem_rvalid_i = 1'b0;

    // Starvation boost under a continuous stream of data writes.
    d_req_i = 1'b1; d_we_i = 1'b1; f_req_i = 1'b1; f_addr_i = 32'h108; mem_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eval_check();
      chk("t3_f_denied", {31'h0, f_gnt_o}, 32'h0);
      advance();
    end
    eval_check();
    chk("t3_f_boost", {31'h0, f_gnt_o}, 32'h1);
    chk("t3_d_lose", {31'h0, d_gnt_o}, 32'h0);
    advance();
    f_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0093;
    step();
    mem_rvalid_i = 1'b0; f_req_i = 1'b1;
    eval_check();
    chk("t3_counter_cleared", {31'h0, d_gnt_o}, 32'h1);
    advance();
    d_req_i = 1'b0; f_req_i = 1'b0; d_we_i = 1'b0;
    step();

    // Outstanding data read blocks everyone for three cycles.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300; mem_gnt_i = 1'b1;
    eval_check();
    chk("t4_d_gnt", {31'h0, d_gnt_o}, 32'h1);
    advance();
    d_req_i = 1'b0; f_req_i = 1'b1; f_addr_i = 32'h10C; dbg_req_i = 1'b1; dbg_addr_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      eval_check();
      chk("t4_no_mem_req", {31'h0, mem_req_o}, 32'h0);
      chk("t4_no_gnt", {29'h0, d_gnt_o, f_gnt_o, dbg_gnt_o}, 32'h0);
      advance();
    end
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_CAFE;
    eval_check();
    chk("t4_d_rvalid", {31'h0, d_rvalid_o}, 32'h1);
    chk("t4_rdata", rdata_o, 32'h0000_CAFE);
    advance();
    mem_rvalid_i = 1'b0;
    eval_check();
    chk("t4_f_gnt_after", {31'h0, f_gnt_o}, 32'h1);
    advance();

    // Debug waits until fetch is done and drops its request.
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0033;
    step();
    mem_rvalid_i = 1'b0; f_addr_i = 32'h110;
    eval_check();
    chk("t5_dbg_blocked", {31'h0, dbg_gnt_o}, 32'h0);
    chk("t5_f_again", {31'h0, f_gnt_o}, 32'h1);
    advance();
    mem_rvalid_i = 1'b1; f_req_i = 1'b0;
    step();
    mem_rvalid_i = 1'b0;
    eval_check();
    chk("t5_dbg_gnt", {31'h0, dbg_gnt_o}, 32'h1);
    chk("t5_dbg_addr", mem_addr_o, 32'h40);
    advance();
    dbg_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_1234;
    eval_check();
    chk("t5_dbg_rvalid", {31'h0, dbg_rvalid_o}, 32'h1);
    chk("t5_dbg_rdata", rdata_o, 32'h0000_1234);
    advance();
    mem_rvalid_i = 1'b0;

    // Reset while a read is outstanding, then a stray response.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h400;
    step();
    d_req_i = 1'b0; rst_i = 1'b1; mem_gnt_i = 1'b0;
    eval_check();
    chk("t6_quiet", {28'h0, mem_req_o, d_gnt_o, f_gnt_o, stall_f_o}, 32'h0);
    advance();
    rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    eval_check();
    chk("t6_stray_d_rvalid", {31'h0, d_rvalid_o}, 32'h0);
    chk("t6_stray_rdata", rdata_o, 32'h0);
    advance();
    mem_rvalid_i = 1'b0;
    f_req_i = 1'b1; f_addr_i = 32'h500; mem_gnt_i = 1'b1;
    eval_check();
    chk("t6_idle_after", {31'h0, f_gnt_o}, 32'h1);
    advance();
    f_req_i = 1'b0; mem_rvalid_i = 1'b1;
    step();
    mem_rvalid_i = 1'b0;

    // Randomized traffic: requests held until granted, memory randomly slow.
    for (int n = 0; n < 400; n++) begin
      if (!d_req_i || e_dg) begin
        d_req_i   = ($urandom_range(0, 2) != 0);
        d_we_i    = $urandom_range(0, 1);
        d_be_i    = 4'($urandom_range(0, 15));
        d_addr_i  = $urandom;
        d_wdata_i = $urandom;
      end
      if (!f_req_i || e_fg) begin
        f_req_i  = ($urandom_range(0, 2) != 0);
        f_addr_i = $urandom;
      end
      if (!dbg_req_i || e_bg) begin
        dbg_req_i  = ($urandom_range(0, 3) == 0);
        dbg_addr_i = $urandom;
      end
      mem_gnt_i    = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = (m_pend != 0) && ($urandom_range(0, 2) != 0);
      mem_rdata_i  = $urandom;
      rst_i        = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between three requesters of the pipelined core:
  - data port: memory stage loads and stores;
  - fetch port: instruction fetch;
  - debug port: testbench read-back through addr/data.
- Sits between the fetch and memory stages and the memory macro.
- Provides request/grant handshakes, at most one outstanding read, and response routing.
- Prevents fetch starvation and drives the fetch stall.

Parameters:
- XLEN, 32, data and address width (taken from the shared package).
- MaxStarve, 4, consecutive denied fetch cycles before fetch is forced to win one arbitration.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- d_req_i  in  1  data port request.
- d_we_i  in  1  data port write enable.
- d_be_i  in  4  data port byte enables.
- d_addr_i  in  XLEN  data port address.
- d_wdata_i  in  XLEN  data port write data.
- d_gnt_o  out  1  data port request accepted this cycle.
- d_rvalid_o  out  1  data port read data valid.
- f_req_i  in  1  fetch request.
- f_addr_i  in  XLEN  fetch address.
- f_gnt_o  out  1  fetch accepted this cycle.
- f_rvalid_o  out  1  fetch data valid.
- dbg_req_i  in  1  debug read request.
- dbg_addr_i  in  XLEN  debug address.
- dbg_gnt_o  out  1  debug accepted this cycle.
- dbg_rvalid_o  out  1  debug data valid.
- rdata_o  out  XLEN  read data, shared by all ports and qualified by the per-port rvalid.
- stall_f_o  out  1  fetch stall, equal to f_req_i & ~f_gnt_o.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_be_o  out  4  memory byte enables.
- mem_addr_o  out  XLEN  memory address.
- mem_wdata_o  out  XLEN  memory write data.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  memory read data valid.
- mem_rdata_i  in  XLEN  memory read data.

Behaviour:
- Reset (synchronous, rst_i=1 at a posedge):
  - state=IDLE, owner=NONE, starve_cnt=0.
  - All outputs 0.
- FSM states:
  - IDLE: no read outstanding.
  - WAIT_RESP: one read outstanding; owner records which port issued it.
- Arbitration in IDLE is combinational, in the same cycle as the request:
  - Normal priority order is data > fetch > debug.
  - If starve_cnt == MaxStarve, the order becomes fetch > data > debug for that cycle.
  - Debug is granted only when neither data nor fetch is requesting.
- Memory drive:
  - The winner's signals are muxed onto mem_*, with mem_req_o=1.
  - Fetch and debug always drive mem_we_o=0 and mem_be_o=4'hF.
- Grant condition: the port's gnt_o = winner & mem_gnt_i, in the same cycle.
  - If mem_gnt_i=0, no grant is issued.
  - The requester must hold its request stable until it is granted.
  - Arbitration is re-evaluated every cycle; there is no lock on the previous winner.
- Accepted write: state stays IDLE; there is no response.
- Accepted read: next state is WAIT_RESP and owner is set to the winner.
- WAIT_RESP:
  - mem_req_o=0 and all grants are 0.
  - When mem_rvalid_i=1: rdata_o=mem_rdata_i, the owner's rvalid=1 in that same cycle, next state is IDLE.
  - rvalid is combinational from mem_rvalid_i, gated by owner.
  - A new grant is possible in the cycle after the rvalid.
- Back-to-back read rate: one read per 2 cycles minimum with a 1-cycle memory. This is accepted by design.
- Starvation counter starve_cnt, 3 bits, saturating at MaxStarve:
  - Increments on every cycle where f_req_i=1 and f_gnt_o=0, including WAIT_RESP cycles.
  - Cleared on f_gnt_o=1 or when f_req_i=0.
- stall_f_o is combinational and is also asserted while fetch waits in WAIT_RESP behind another owner.
- mem_rvalid_i in IDLE is a protocol error:
  - It is ignored; no rvalid is forwarded.
  - A simulation assertion fires.
- Reset during WAIT_RESP:
  - Returns to IDLE and discards the owner.
  - A late mem_rvalid_i is then ignored as above.
- Address width: addresses are passed through unmodified. No alignment checks; the requester is responsible.

Decomposition:
- riscv_pkg gains:
  - typedef enum arb_owner_e {OWN_NONE, OWN_DATA, OWN_FETCH, OWN_DBG};
  - typedef enum arb_state_e {ARB_IDLE, ARB_WAIT_RESP}.
- XLEN comes from riscv_pkg.
- One natural sub-module: arb_prio_sel.
  - Combinational fixed-priority picker with a fetch-boost input.
  - Keeps the mux and grant logic separate from the FSM and counter.

Test Plan:
- Fetch-only read:
  - Stimulus: f_req=1, addr=0x100; memory gnt same cycle, rvalid one cycle later with 0x00000013.
  - Required: f_gnt=1 in cycle 0; f_rvalid=1 and rdata_o=0x13 in cycle 1; stall_f=0 in cycle 0.
- Data write vs fetch:
  - Stimulus: d_req=1, we=1, addr=0x200, wdata=0xDEADBEEF, be=4'hF, with f_req=1 simultaneously.
  - Required: d_gnt=1, mem_we=1, f_gnt=0, stall_f=1; fetch granted the next cycle.
- Starvation boost:
  - Stimulus: d_req held high with writes; f_req held high.
  - Required: f_gnt=0 for 4 cycles; in the 5th cycle f_gnt=1, d_gnt=0; starve_cnt=0 after.
- Outstanding read blocks:
  - Stimulus: data read granted; memory delays rvalid 3 cycles; f_req and dbg_req asserted.
  - Required: no grants and mem_req=0 during the wait; d_rvalid=1 on the rvalid cycle; f_gnt the following cycle.
- Debug lowest priority:
  - Stimulus: dbg_req=1 with addr=0x40 alongside f_req=1.
  - Required: debug is granted only after fetch completes and f_req drops; dbg_rvalid is returned with the memory data.
- Reset mid-read:
  - Stimulus: rst_i asserted in WAIT_RESP, then a stray mem_rvalid_i.
  - Required: all outputs 0; no rvalid forwarded; state IDLE.
